// File: rtl/addsub_result_accumulator_if.sv
// Handshake bundle between the add/sub result stream, the block accumulator and its consumer.
// The master drives samples, clear and out_ready; the slave is the accumulator.
interface addsub_result_accumulator_if #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 8
);
    logic                    clear;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_sat;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/addsub_result_accumulator.sv
// Sums COUNT signed add/sub results into a saturating accumulator and holds the block sum
// (with a sticky saturation flag) until the downstream consumer takes it.
module addsub_result_accumulator #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 8,
    parameter int COUNT = 4
) (
    input  logic clk,
    input  logic rst,
    addsub_result_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]              state_reg, state_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    sat_reg, sat_next;

    logic             accept;
    logic [ACC_W:0]   in_ext;
    logic [ACC_W:0]   sum_wide;
    logic             sum_ovf;
    logic [ACC_W-1:0] sum_clamped;
    logic [CNT_W-1:0] cnt_inc;

    // Sign-extend the incoming result one bit past the accumulator so the add cannot wrap.
    for (genvar gi = 0; gi <= ACC_W; gi++) begin : g_sext
        if (gi < IN_W) begin : g_data
            assign in_ext[gi] = bus.in_data[gi];
        end else begin : g_sign
            assign in_ext[gi] = bus.in_data[IN_W-1];
        end
    end

    assign accept      = bus.in_valid && bus.in_ready;
    assign sum_wide    = {acc_reg[ACC_W-1], acc_reg} + in_ext;
    assign sum_ovf     = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign sum_clamped = sum_ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
    assign cnt_inc     = cnt_reg + CNT_ONE;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        sat_next   = sat_reg;
        if (bus.clear) begin
            // Abort wins over any same-cycle input or output transfer.
            state_next = S_IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            sat_next   = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        acc_next   = in_ext[ACC_W-1:0];
                        cnt_next   = CNT_ONE;
                        sat_next   = 1'b0;
                        state_next = (COUNT == 1) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        acc_next = sum_clamped;
                        cnt_next = cnt_inc;
                        sat_next = sat_reg | sum_ovf;
                        if (cnt_inc == COUNT_C) begin
                            state_next = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_next = S_IDLE;
                        acc_next   = '0;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    acc_next   = '0;
                    cnt_next   = '0;
                    sat_next   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            sat_reg   <= sat_next;
        end
    end

    // Outputs come straight from state, so they hold steady under back-pressure.
    assign bus.in_ready  = (state_reg != S_DONE);
    assign bus.out_valid = (state_reg == S_DONE);
    assign bus.out_data  = (state_reg == S_DONE) ? acc_reg : '0;
    assign bus.out_sat   = (state_reg == S_DONE) && sat_reg;
endmodule
